// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, empty/full flags and overflow/underflow pulses
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  empty,
  output logic                  full,
  output logic                  wr_err,
  output logic                  rd_err,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] count;
  logic wr_ok, rd_ok;
  assign empty = count == '0;
  assign full = count == (ADDR_WIDTH+1)'(DEPTH);
  assign wr_ok = we & ~full;
  assign rd_ok = re & ~empty;
  always_ff @(posedge clk)
    if (!rst && wr_ok) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      dout <= '0;
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      wr_err <= we & full;
      rd_err <= re & empty;
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        dout <= mem[rd_ptr];
      end
      count <= (wr_ok && !rd_ok) ? count + (ADDR_WIDTH+1)'(1) :
               (rd_ok && !wr_ok) ? count - (ADDR_WIDTH+1)'(1) : count;
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo
module tb_sync_fifo;
  logic clk = 0, rst = 1, we = 0, re = 0;
  logic [7:0] din = 0, dout;
  logic empty, full, wr_err, rd_err;
  int checks = 0, failures = 0;

  sync_fifo dut (.clk(clk), .rst(rst), .we(we), .re(re), .din(din),
                 .empty(empty), .full(full), .wr_err(wr_err), .rd_err(rd_err), .dout(dout));

  always #5 clk = ~clk;

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    we = w; re = r; din = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1;
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (dout !== 8'd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", dout); end
    checks++; if (wr_err !== 1'b0 || rd_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", wr_err, rd_err); end
    rst = 0;
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 8'(i));
      checks++; if (full !== (i >= 8)) begin failures++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, i >= 8); end
      checks++; if (wr_err !== (i >= 9)) begin failures++; $display("FAIL fill_wr_err i=%0d got=%b exp=%b", i, wr_err, i >= 9); end
      checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, empty); end
    end
  endtask

  task automatic test_partial_read;
    for (int i = 1; i <= 2; i++) begin
      step(0, 1, 8'h00);
      checks++; if (dout !== 8'(i)) begin failures++; $display("FAIL pread_dout i=%0d got=%0d exp=%0d", i, dout, i); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL pread_full i=%0d got=%b exp=0", i, full); end
      checks++; if (rd_err !== 1'b0 || wr_err !== 1'b0) begin failures++; $display("FAIL pread_err i=%0d got=%b%b exp=00", i, wr_err, rd_err); end
    end
  endtask

  task automatic test_refill;
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 8'd10);
      checks++; if (full !== (i >= 2)) begin failures++; $display("FAIL refill_full i=%0d got=%b exp=%b", i, full, i >= 2); end
      checks++; if (wr_err !== (i >= 3)) begin failures++; $display("FAIL refill_wr_err i=%0d got=%b exp=%b", i, wr_err, i >= 3); end
    end
  endtask

  task automatic test_drain;
    logic [7:0] exp [10] = '{3, 4, 5, 6, 7, 8, 10, 10, 10, 10};
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 8'h00);
      checks++; if (dout !== exp[i-1]) begin failures++; $display("FAIL drain_dout i=%0d got=%0d exp=%0d", i, dout, exp[i-1]); end
      checks++; if (empty !== (i >= 8)) begin failures++; $display("FAIL drain_empty i=%0d got=%b exp=%b", i, empty, i >= 8); end
      checks++; if (rd_err !== (i >= 9)) begin failures++; $display("FAIL drain_rd_err i=%0d got=%b exp=%b", i, rd_err, i >= 9); end
    end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 3; i++) step(1, 0, 8'(20 + i));
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 8'(23 + i));
      checks++; if (dout !== 8'(20 + i)) begin failures++; $display("FAIL sim_mid_dout i=%0d got=%0d exp=%0d", i, dout, 20 + i); end
      checks++; if (empty !== 1'b0 || full !== 1'b0 || wr_err !== 1'b0 || rd_err !== 1'b0) begin
        failures++; $display("FAIL sim_mid_flags i=%0d got=e%b f%b w%b r%b exp=0000", i, empty, full, wr_err, rd_err); end
    end
    for (int i = 0; i < 5; i++) step(1, 0, 8'(27 + i));
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL sim_prefull got=%b exp=1", full); end
    step(1, 1, 8'd99);
    checks++; if (dout !== 8'd24) begin failures++; $display("FAIL sim_full_dout got=%0d exp=24", dout); end
    checks++; if (wr_err !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL sim_full_flags got=w%b f%b exp=w1 f0", wr_err, full); end
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 8'h00);
      checks++; if (dout !== 8'(25 + i)) begin failures++; $display("FAIL sim_drain_dout i=%0d got=%0d exp=%0d", i, dout, 25 + i); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL sim_drain_empty got=%b exp=1", empty); end
    step(1, 1, 8'd77);
    checks++; if (rd_err !== 1'b1 || wr_err !== 1'b0) begin failures++; $display("FAIL sim_empty_err got=w%b r%b exp=w0 r1", wr_err, rd_err); end
    checks++; if (dout !== 8'd31) begin failures++; $display("FAIL sim_empty_dout got=%0d exp=31", dout); end
    checks++; if (empty !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL sim_empty_flags got=e%b f%b exp=e0 f0", empty, full); end
    step(0, 1, 8'h00);
    checks++; if (dout !== 8'd77 || empty !== 1'b1) begin failures++; $display("FAIL sim_single got=%0d e%b exp=77 e1", dout, empty); end
    step(1, 0, 8'd40);
    step(1, 0, 8'd41);
    rst = 1;
    step(1, 1, 8'd42);
    rst = 0;
    checks++; if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'd0) begin
      failures++; $display("FAIL sim_rst got=e%b f%b d%0d exp=e1 f0 d0", empty, full, dout); end
    checks++; if (wr_err !== 1'b0 || rd_err !== 1'b0) begin failures++; $display("FAIL sim_rst_err got=%b%b exp=00", wr_err, rd_err); end
    step(0, 1, 8'h00);
    checks++; if (rd_err !== 1'b1 || dout !== 8'd0) begin failures++; $display("FAIL sim_rst_gone got=r%b d%0d exp=r1 d0", rd_err, dout); end
  endtask

  initial begin
    test_reset;
    test_fill_overflow;
    test_partial_read;
    test_refill;
    test_drain;
    test_simultaneous;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
